// File: rtl/spi_slave_sram.sv
// SPI mode-0 slave SRAM with write-enable latch and status read.
// All SPI pins are oversampled in the core clock domain.
module spi_slave_sram #(
  parameter int          ADDR_BYTES  = 2,
  parameter int          MEM_AW      = 10,
  parameter logic [7:0]  FILL_VALUE  = 8'hCA,
  parameter int          SYNC_STAGES = 2
) (
  input  logic              clk_core_i,
  input  logic              rst_n_i,
  input  logic              spi_sclk_i,
  input  logic              spi_cs_i,
  input  logic              spi_mosi_i,
  output logic              spi_miso_o,
  output logic              spi_miso_oe_o,
  output logic              wel_o,
  input  logic [MEM_AW-1:0] bd_addr_i,
  output logic [7:0]        bd_data_o
);

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR, RD_DATA, WR_DATA, STATUS, IGNORE
  } state_t;

  localparam logic [1:0] LAST_BYTE = 2'(ADDR_BYTES - 1);

  logic [SYNC_STAGES-1:0] sclk_sy, cs_sy, mosi_sy;
  logic sclk_s, cs_s, mosi_s;
  logic sclk_q, cs_q;
  logic rise, fall, byte_end;

  state_t      state;
  logic [2:0]  bit_cnt;
  logic [1:0]  byte_cnt;
  logic [7:0]  sh;
  logic [7:0]  rx_byte;
  logic [MEM_AW-1:0] addr, addr_nx, addr_full;
  logic is_wr, skip, upd, mem_we;

  logic [7:0] mem [0:2**MEM_AW-1] = '{default: FILL_VALUE};

  assign sclk_s    = sclk_sy[SYNC_STAGES-1];
  assign cs_s      = cs_sy[SYNC_STAGES-1];
  assign mosi_s    = mosi_sy[SYNC_STAGES-1];
  assign rise      = sclk_s & ~sclk_q;
  assign fall      = ~sclk_s & sclk_q;
  assign byte_end  = rise & (bit_cnt == 3'd7);
  assign rx_byte   = {sh[6:0], mosi_s};
  assign addr_nx   = addr + 1'b1;
  assign addr_full = {addr[MEM_AW-2:0], mosi_s};
  assign mem_we    = ~cs_s & (state == WR_DATA) & byte_end;

  // input synchronizers; CS idles high
  always_ff @(posedge clk_core_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sclk_sy <= '0;
      cs_sy   <= '1;
      mosi_sy <= '0;
    end else begin
      sclk_sy <= {sclk_sy[SYNC_STAGES-2:0], spi_sclk_i};
      cs_sy   <= {cs_sy[SYNC_STAGES-2:0], spi_cs_i};
      mosi_sy <= {mosi_sy[SYNC_STAGES-2:0], spi_mosi_i};
    end
  end

  // protocol FSM, shifter and registered MISO
  always_ff @(posedge clk_core_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      byte_cnt      <= '0;
      sh            <= '0;
      addr          <= '0;
      is_wr         <= 1'b0;
      skip          <= 1'b0;
      upd           <= 1'b0;
      wel_o         <= 1'b0;
      spi_miso_o    <= 1'b1;
      spi_miso_oe_o <= 1'b0;
      sclk_q        <= 1'b0;
      cs_q          <= 1'b1;
    end else begin
      sclk_q <= sclk_s;
      cs_q   <= cs_s;
      upd    <= 1'b0;
      if (cs_s) begin
        state         <= IDLE;
        bit_cnt       <= '0;
        byte_cnt      <= '0;
        addr          <= '0;
        skip          <= 1'b0;
        spi_miso_o    <= 1'b1;
        spi_miso_oe_o <= 1'b0;
        is_wr         <= 1'b0;
        if (is_wr) wel_o <= 1'b0;
      end else begin
        if (upd) begin
          spi_miso_o    <= sh[7];
          spi_miso_oe_o <= 1'b1;
        end
        if (rise) bit_cnt <= bit_cnt + 3'd1;
        case (state)
          IDLE: begin
            bit_cnt <= '0;
            if (cs_q) state <= CMD;
          end
          CMD: if (rise) begin
            sh <= rx_byte;
            if (bit_cnt == 3'd7) begin
              case (rx_byte)
                8'h03: state <= ADDR;
                8'h02: begin
                  state <= ADDR;
                  is_wr <= 1'b1;
                end
                8'h05: begin
                  sh    <= {6'b0, wel_o, 1'b0};
                  upd   <= 1'b1;
                  skip  <= 1'b1;
                  state <= STATUS;
                end
                8'h06: begin
                  wel_o <= 1'b1;
                  state <= IGNORE;
                end
                8'h04: begin
                  wel_o <= 1'b0;
                  state <= IGNORE;
                end
                default: state <= IGNORE;
              endcase
            end
          end
          ADDR: if (rise) begin
            addr <= addr_full;
            if (bit_cnt == 3'd7) begin
              byte_cnt <= byte_cnt + 2'd1;
              if (byte_cnt == LAST_BYTE) begin
                if (!is_wr) begin
                  sh    <= mem[addr_full];
                  upd   <= 1'b1;
                  skip  <= 1'b1;
                  state <= RD_DATA;
                end else if (wel_o) begin
                  state <= WR_DATA;
                end else begin
                  state <= IGNORE;
                end
              end
            end
          end
          RD_DATA, STATUS: if (fall) begin
            if (skip) begin
              skip <= 1'b0;
            end else if (bit_cnt == 3'd0) begin
              upd <= 1'b1;
              if (state == RD_DATA) begin
                addr <= addr_nx;
                sh   <= mem[addr_nx];
              end else begin
                sh <= {6'b0, wel_o, 1'b0};
              end
            end else begin
              upd <= 1'b1;
              sh  <= {sh[6:0], 1'b0};
            end
          end
          WR_DATA: if (rise) begin
            sh <= rx_byte;
            if (bit_cnt == 3'd7) addr <= addr_nx;
          end
          IGNORE: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

  // memory write port
  always_ff @(posedge clk_core_i) begin
    if (mem_we) mem[addr] <= rx_byte;
  end

  // backdoor read, old data on same-cycle write
  always_ff @(posedge clk_core_i or negedge rst_n_i) begin
    if (!rst_n_i) bd_data_o <= '0;
    else          bd_data_o <= mem[bd_addr_i];
  end

endmodule

// File: tb/tb_spi_slave_sram.sv
// Bench for spi_slave_sram: SPI master driver,
// reference memory model and read scoreboard.
module tb_spi_slave_sram;

  localparam int HALF = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclk = 1'b0;
  logic       cs = 1'b1;
  logic       mosi = 1'b0;
  logic       miso, miso_oe, wel;
  logic [9:0] bd_addr = '0;
  logic [7:0] bd_data;

  int n_run = 0;
  int n_fail = 0;

  logic [7:0] model [0:1023];
  logic       model_wel = 1'b0;
  logic [7:0] exp_q [$];

  spi_slave_sram dut (
    .clk_core_i   (clk),
    .rst_n_i      (rst_n),
    .spi_sclk_i   (sclk),
    .spi_cs_i     (cs),
    .spi_mosi_i   (mosi),
    .spi_miso_o   (miso),
    .spi_miso_oe_o(miso_oe),
    .wel_o        (wel),
    .bd_addr_i    (bd_addr),
    .bd_data_o    (bd_data)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic xfer(input logic [7:0] tx, output logic [7:0] rx,
                      output logic oe_all, output logic oe_any);
    rx = '0;
    oe_all = 1'b1;
    oe_any = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      mosi = tx[i];
      wait_cyc(HALF);
      rx = {rx[6:0], miso};
      oe_all &= miso_oe;
      oe_any |= miso_oe;
      sclk = 1'b1;
      wait_cyc(HALF);
      sclk = 1'b0;
    end
  endtask

  task automatic cs_begin();
    cs = 1'b0;
    wait_cyc(HALF);
  endtask

  task automatic cs_end(input string tag);
    wait_cyc(HALF);
    cs = 1'b1;
    wait_cyc(HALF);
    chk({tag, "_miso_rel"}, miso, 1'b1);
    chk({tag, "_oe_rel"}, miso_oe, 1'b0);
  endtask

  task automatic send_hdr(input logic [7:0] op, input logic [15:0] a);
    logic [7:0] rx;
    logic oa, on;
    xfer(op, rx, oa, on);
    chk("cmd_oe", on, 1'b0);
    xfer(a[15:8], rx, oa, on);
    xfer(a[7:0], rx, oa, on);
    chk("addr_oe", on, 1'b0);
  endtask

  task automatic do_read(input logic [15:0] a, input int n);
    logic [7:0] rx;
    logic oa, on;
    cs_begin();
    send_hdr(8'h03, a);
    for (int k = 0; k < n; k++) begin
      exp_q.push_back(model[10'(a + 16'(k))]);
      xfer(8'h00, rx, oa, on);
      chk("rd_data", rx, exp_q.pop_front());
      chk("rd_oe", oa, 1'b1);
    end
    cs_end("rd");
  endtask

  task automatic do_write(input logic [15:0] a, input logic [15:0] d,
                          input int n);
    logic [7:0] rx;
    logic oa, on;
    cs_begin();
    send_hdr(8'h02, a);
    for (int k = 0; k < n; k++) begin
      logic [7:0] b;
      b = (k == 0) ? d[15:8] : d[7:0];
      xfer(b, rx, oa, on);
      chk("wr_oe", on, 1'b0);
      if (model_wel) model[10'(a + 16'(k))] = b;
    end
    cs_end("wr");
    model_wel = 1'b0;
    chk("wr_wel_clr", wel, 1'b0);
  endtask

  task automatic do_op(input logic [7:0] op);
    logic [7:0] rx;
    logic oa, on;
    cs_begin();
    xfer(op, rx, oa, on);
    cs_end("op");
    if (op == 8'h06) model_wel = 1'b1;
    if (op == 8'h04) model_wel = 1'b0;
    chk("op_wel", wel, model_wel);
  endtask

  task automatic do_rdsr(input int n);
    logic [7:0] rx;
    logic oa, on;
    cs_begin();
    xfer(8'h05, rx, oa, on);
    for (int k = 0; k < n; k++) begin
      exp_q.push_back({6'b0, model_wel, 1'b0});
      xfer(8'h00, rx, oa, on);
      chk("rdsr", rx, exp_q.pop_front());
      chk("rdsr_oe", oa, 1'b1);
    end
    cs_end("rdsr");
  endtask

  task automatic bd_chk(input logic [9:0] a);
    bd_addr = a;
    wait_cyc(2);
    chk("bd", bd_data, model[a]);
  endtask

  initial begin
    logic [7:0] rx;
    logic oa, on;
    for (int i = 0; i < 1024; i++) model[i] = 8'hCA;

    wait_cyc(4);
    chk("rst_miso", miso, 1'b1);
    chk("rst_oe", miso_oe, 1'b0);
    chk("rst_wel", wel, 1'b0);
    chk("rst_bd", bd_data, 8'h00);
    rst_n = 1'b1;
    wait_cyc(4);

    do_read(16'h0010, 3);

    do_op(8'h06);
    do_write(16'h0100, 16'hA55A, 2);
    bd_chk(10'h100);
    bd_chk(10'h101);
    bd_chk(10'h102);

    do_write(16'h0200, 16'h1100, 1);
    bd_chk(10'h200);
    do_rdsr(1);

    do_op(8'h06);
    do_write(16'hFFFF, 16'h0102, 2);
    bd_chk(10'h3FF);
    bd_chk(10'h000);
    do_read(16'h03FF, 2);

    do_op(8'h06);
    do_rdsr(2);
    cs_begin();
    xfer(8'h9F, rx, oa, on);
    for (int k = 0; k < 2; k++) begin
      xfer(8'h00, rx, oa, on);
      chk("ign_miso", rx, 8'hFF);
      chk("ign_oe", on, 1'b0);
    end
    cs_end("ign");
    chk("ign_wel", wel, 1'b1);
    do_op(8'h04);

    do_op(8'h06);
    cs_begin();
    send_hdr(8'h02, 16'h0300);
    for (int i = 0; i < 4; i++) begin
      mosi = i[0];
      wait_cyc(HALF);
      sclk = 1'b1;
      wait_cyc(HALF);
      sclk = 1'b0;
    end
    wait_cyc(2);
    rst_n = 1'b0;
    cs = 1'b1;
    model_wel = 1'b0;
    wait_cyc(2);
    chk("mid_rst_wel", wel, 1'b0);
    chk("mid_rst_miso", miso, 1'b1);
    chk("mid_rst_oe", miso_oe, 1'b0);
    rst_n = 1'b1;
    wait_cyc(HALF);
    bd_chk(10'h300);
    do_read(16'h0100, 2);
    do_rdsr(1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
